// File: rtl/uart_defs_pkg.sv
// ---------------------------------------------------------------------------
// uart_defs : shared UART state encodings and divider / width helpers.
// Revision  : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

package uart_defs;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  // Clocks per line bit, rounded to the nearest integer.
  function automatic int calc_div(input int clock_rate, input int baud_rate);
    return (clock_rate + baud_rate / 2) / baud_rate;
  endfunction

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_baud_tick.sv
// ---------------------------------------------------------------------------
// uart_baud_tick : restartable bit-period counter; tick on the last clock.
// Revision       : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module uart_baud_tick
  import uart_defs::*;
#(
  parameter int DIV = 1250
) (
  input  logic clk,
  input  logic rstN,
  input  logic restart,
  output logic tick
);

  localparam int CW = (clog2(DIV) > 0) ? clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tick = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (restart || tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart8_tx.sv
// ---------------------------------------------------------------------------
// uart8_tx : byte-wide 8N1/8N2 UART transmitter with one-entry holding buffer.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module uart8_tx
  import uart_defs::*;
#(
  parameter int CLOCK_RATE = 12000000,
  parameter int BAUD_RATE  = 9600,
  parameter int STOP_BITS  = 1
) (
  input  logic       clk,
  input  logic       rstN,
  input  logic       txEn,
  input  logic       txStart,
  input  logic [7:0] in,
  output logic       txReady,
  output logic       txBusy,
  output logic       txDone,
  output logic       tx
);

  localparam int DIV = calc_div(CLOCK_RATE, BAUD_RATE);
  localparam logic LAST_STOP = 1'(STOP_BITS - 1);

  uart_state_e state_q, state_d;
  logic        hold_full_q, hold_full_d;
  logic [7:0]  hold_q, hold_d;
  logic [7:0]  shift_q, shift_d;
  logic [2:0]  bit_q, bit_d;
  logic        stop_q, stop_d;
  logic        tx_q, tx_d;
  logic        done_q, done_d;
  logic        launch;
  logic        baud_tick;
  logic        baud_restart;

  uart_baud_tick #(
    .DIV (DIV)
  ) u_baud (
    .clk     (clk),
    .rstN    (rstN),
    .restart (baud_restart),
    .tick    (baud_tick)
  );

  // Every state change realigns the bit period to the new state.
  assign baud_restart = (state_d != state_q);

  always_comb begin
    state_d     = state_q;
    hold_full_d = hold_full_q;
    hold_d      = hold_q;
    shift_d     = shift_q;
    bit_d       = bit_q;
    stop_d      = stop_q;
    done_d      = 1'b0;
    launch      = 1'b0;

    case (state_q)
      IDLE: begin
        if (txEn && hold_full_q) begin
          launch = 1'b1;
        end
      end
      START: begin
        if (baud_tick) begin
          state_d = DATA;
          bit_d   = 3'd0;
        end
      end
      DATA: begin
        if (baud_tick) begin
          shift_d = shift_q >> 1;
          if (bit_q == 3'd7) begin
            state_d = STOP;
            stop_d  = 1'b0;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      STOP: begin
        if (baud_tick) begin
          if (stop_q == LAST_STOP) begin
            done_d = 1'b1;
            if (txEn && hold_full_q) begin
              launch = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end else begin
            stop_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (launch) begin
      state_d     = START;
      shift_d     = hold_q;
      hold_full_d = 1'b0;
    end

    // Accept and launch are exclusive: accept needs an empty buffer.
    if (txStart && !hold_full_q) begin
      hold_full_d = 1'b1;
      hold_d      = in;
    end

    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q     <= IDLE;
      hold_full_q <= 1'b0;
      hold_q      <= 8'h00;
      shift_q     <= 8'h00;
      bit_q       <= 3'd0;
      stop_q      <= 1'b0;
      tx_q        <= 1'b1;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_full_q <= hold_full_d;
      hold_q      <= hold_d;
      shift_q     <= shift_d;
      bit_q       <= bit_d;
      stop_q      <= stop_d;
      tx_q        <= tx_d;
      done_q      <= done_d;
    end
  end

  assign tx      = tx_q;
  assign txReady = !hold_full_q;
  assign txBusy  = (state_q != IDLE);
  assign txDone  = done_q;

endmodule

`default_nettype wire
